// File: rtl/gshare_pht_pkg.sv
`default_nettype none
// ============================================================================
// Module   : gshare_pht_pkg
// Brief    : Shared types and constants for the gshare pattern history table.
// Revision : 1.0 - initial release
// ============================================================================
package gshare_pht_pkg;

    localparam int c_G_WIDTH_DEFAULT = 9;

    typedef logic [1:0] ctr_t;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Weakly not-taken: one taken outcome flips the prediction.
    localparam ctr_t c_INIT_CTR = 2'b01;

endpackage
`default_nettype wire

// File: rtl/gshare_pht_if.sv
`default_nettype none
// ============================================================================
// Module   : gshare_pht_if
// Brief    : Prediction/update bus between the front end and the gshare PHT.
// Revision : 1.0 - initial release
// ============================================================================
interface gshare_pht_if #(
    parameter int G_WIDTH = gshare_pht_pkg::c_G_WIDTH_DEFAULT
) ();

    logic             predValid;
    logic [G_WIDTH:0] predPC;
    logic [G_WIDTH:0] globalHistory;
    logic             updValid;
    logic [G_WIDTH:0] updIndex;
    logic             updTaken;

    logic             ready;
    logic             predOutValid;
    logic             predTaken;
    logic [G_WIDTH:0] predIndex;
    logic             wasTaken;
    logic             resolved;

    modport master (
        output predValid, predPC, globalHistory, updValid, updIndex, updTaken,
        input  ready, predOutValid, predTaken, predIndex, wasTaken, resolved
    );

    modport slave (
        input  predValid, predPC, globalHistory, updValid, updIndex, updTaken,
        output ready, predOutValid, predTaken, predIndex, wasTaken, resolved
    );

endinterface
`default_nettype wire

// File: rtl/gshare_pht_sat_counter2.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter2
// Brief    : Combinational next value of a 2-bit saturating counter.
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter2
    import gshare_pht_pkg::*;
(
    input  wire ctr_t i_ctr,
    input  wire logic i_taken,
    output ctr_t      o_next
);

    always_comb begin
        o_next = i_ctr;
        if (i_taken) begin
            if (i_ctr != 2'b11) begin
                o_next = i_ctr + 2'd1;
            end
        end else begin
            if (i_ctr != 2'b00) begin
                o_next = i_ctr - 2'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/gshare_pht.sv
`default_nettype none
// ============================================================================
// Module   : gshare_pht
// Brief    : Gshare pattern history table with 1-cycle prediction and a
//            2-stage forwarded read-modify-write update path.
// Revision : 1.0 - initial release
// ============================================================================
module gshare_pht
    import gshare_pht_pkg::*;
#(
    parameter int   G_WIDTH  = c_G_WIDTH_DEFAULT,
    parameter ctr_t INIT_CTR = c_INIT_CTR
) (
    input  wire logic   clk,
    input  wire logic   reset,
    gshare_pht_if.slave bus
);

    localparam int IW    = G_WIDTH + 1;
    localparam int DEPTH = 1 << IW;

    typedef logic [IW-1:0] idx_t;

    ctr_t   r_pht [DEPTH];

    state_t r_state;
    state_t w_state_nxt;
    idx_t   r_init_ptr;
    logic   w_init_we;
    logic   w_run;

    logic   r_pred_valid;
    logic   r_pred_taken;
    idx_t   r_pred_idx;

    logic   r_s2_valid;
    idx_t   r_s2_idx;
    ctr_t   r_s2_ctr;
    logic   r_s2_taken;
    ctr_t   w_s2_next;

    logic   w_we;
    idx_t   w_waddr;
    ctr_t   w_wdata;

    idx_t   w_pred_idx;
    ctr_t   w_pred_ctr;
    ctr_t   w_upd_ctr;

    // ------------------------------------------------------------------
    // Init / run state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_init_we   = 1'b0;
        case (r_state)
            INIT: begin
                w_init_we = 1'b1;
                if (r_init_ptr == idx_t'(DEPTH - 1)) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_state_nxt = RUN;
            end
        endcase
    end

    assign w_run = (r_state == RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_init_ptr <= '0;
        end else if (w_init_we) begin
            r_init_ptr <= r_init_ptr + idx_t'(1);
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: saturate and write back
    // ------------------------------------------------------------------
    sat_counter2 u_sat (
        .i_ctr   (r_s2_ctr),
        .i_taken (r_s2_taken),
        .o_next  (w_s2_next)
    );

    // The init sweep shares the single write port with the update path.
    always_comb begin
        if (w_init_we) begin
            w_we    = 1'b1;
            w_waddr = r_init_ptr;
            w_wdata = INIT_CTR;
        end else begin
            w_we    = r_s2_valid;
            w_waddr = r_s2_idx;
            w_wdata = w_s2_next;
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_pht[w_waddr] <= w_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Reads with bypass of the value stage 2 is writing this cycle
    // ------------------------------------------------------------------
    assign w_pred_idx = bus.predPC ^ bus.globalHistory;

    always_comb begin
        w_pred_ctr = r_pht[w_pred_idx];
        if (r_s2_valid && (r_s2_idx == w_pred_idx)) begin
            w_pred_ctr = w_s2_next;
        end
    end

    always_comb begin
        w_upd_ctr = r_pht[bus.updIndex];
        if (r_s2_valid && (r_s2_idx == bus.updIndex)) begin
            w_upd_ctr = w_s2_next;
        end
    end

    // ------------------------------------------------------------------
    // Prediction output register and stage-1 capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pred_valid <= 1'b0;
            r_pred_taken <= 1'b0;
            r_pred_idx   <= '0;
            r_s2_valid   <= 1'b0;
            r_s2_idx     <= '0;
            r_s2_ctr     <= '0;
            r_s2_taken   <= 1'b0;
        end else begin
            r_pred_valid <= w_run && bus.predValid;
            if (w_run && bus.predValid) begin
                r_pred_idx   <= w_pred_idx;
                r_pred_taken <= w_pred_ctr[1];
            end
            r_s2_valid <= w_run && bus.updValid;
            if (w_run && bus.updValid) begin
                r_s2_idx   <= bus.updIndex;
                r_s2_ctr   <= w_upd_ctr;
                r_s2_taken <= bus.updTaken;
            end
        end
    end

    assign bus.ready        = w_run;
    assign bus.predOutValid = r_pred_valid;
    assign bus.predTaken    = r_pred_taken;
    assign bus.predIndex    = r_pred_idx;
    assign bus.wasTaken     = r_s2_taken;
    assign bus.resolved     = r_s2_valid;

endmodule
`default_nettype wire

// File: tb/tb_gshare_pht.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_gshare_pht
// Brief    : Scoreboard bench for gshare_pht (predictions, updates, resets).
// Revision : 1.0 - initial release
// ============================================================================
module tb_gshare_pht;
    import gshare_pht_pkg::*;

    localparam int G_WIDTH = 9;
    localparam int IW      = G_WIDTH + 1;
    localparam int DEPTH   = 1 << IW;

    typedef logic [IW-1:0] idx_t;
    typedef struct {
        idx_t idx;
        logic taken;
    } pred_exp_t;

    logic clk = 1'b0;
    logic reset;

    int errors = 0;
    int checks = 0;

    pred_exp_t  pred_q[$];
    logic       res_q[$];
    logic [1:0] model [DEPTH];

    gshare_pht_if #(.G_WIDTH(G_WIDTH)) bus ();

    gshare_pht #(
        .G_WIDTH  (G_WIDTH),
        .INIT_CTR (2'b01)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not reach its summary");
        $fatal(1);
    end

    function automatic logic [1:0] sat(input logic [1:0] c, input logic t);
        if (t) return (c == 2'd3) ? c : c + 2'd1;
        return (c == 2'd0) ? c : c - 2'd1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) model[i] = 2'b01;
        pred_q.delete();
        res_q.delete();
    endtask

    // Pops and compares whatever the DUT produces, flagging unexpected pulses.
    task automatic monitor();
        pred_exp_t e;
        logic      t;
        forever begin
            @(negedge clk);
            if (bus.predOutValid === 1'b1) begin
                checks++;
                if (pred_q.size() == 0) begin
                    errors++;
                    $display("FAIL pred_unexpected: predOutValid=1 idx=%h with nothing expected", bus.predIndex);
                end else begin
                    e = pred_q.pop_front();
                    if (bus.predIndex !== e.idx || bus.predTaken !== e.taken) begin
                        errors++;
                        $display("FAIL pred: got idx=%h taken=%b, want idx=%h taken=%b",
                                 bus.predIndex, bus.predTaken, e.idx, e.taken);
                    end
                end
            end
            if (bus.resolved === 1'b1) begin
                checks++;
                if (res_q.size() == 0) begin
                    errors++;
                    $display("FAIL resolved_unexpected: resolved=1 wasTaken=%b with nothing expected", bus.wasTaken);
                end else begin
                    t = res_q.pop_front();
                    if (bus.wasTaken !== t) begin
                        errors++;
                        $display("FAIL resolved: got wasTaken=%b, want %b", bus.wasTaken, t);
                    end
                end
            end
        end
    endtask

    task automatic drive(input logic pv, input idx_t pc, input idx_t gh,
                         input logic uv, input idx_t ui, input logic ut);
        pred_exp_t e;
        idx_t      p;
        bus.predValid     = pv;
        bus.predPC        = pc;
        bus.globalHistory = gh;
        bus.updValid      = uv;
        bus.updIndex      = ui;
        bus.updTaken      = ut;
        p = pc ^ gh;
        if (pv) begin
            e.idx   = p;
            e.taken = model[p][1];
            pred_q.push_back(e);
        end
        if (uv) begin
            res_q.push_back(ut);
            model[ui] = sat(model[ui], ut);
        end
        @(posedge clk); #1;
        bus.predValid = 1'b0;
        bus.updValid  = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((pred_q.size() != 0 || res_q.size() != 0) && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (pred_q.size() != 0 || res_q.size() != 0) begin
            errors++;
            $display("FAIL %s drain: %0d predictions and %0d resolutions outstanding, want 0",
                     name, pred_q.size(), res_q.size());
        end
    endtask

    task automatic count_init(output int n);
        n = 0;
        while (bus.ready !== 1'b1 && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.ready, bus.predOutValid, bus.predTaken, bus.predIndex, bus.wasTaken, bus.resolved} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b pv=%b pt=%b pi=%h wt=%b res=%b, want all 0",
                     bus.ready, bus.predOutValid, bus.predTaken, bus.predIndex, bus.wasTaken, bus.resolved);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        // Requests during the sweep must be ignored.
        n = 0;
        while (bus.ready !== 1'b1 && n < 2000) begin
            bus.predValid     = (n >= 10 && n < 20);
            bus.predPC        = 10'h005;
            bus.globalHistory = 10'h000;
            bus.updValid      = (n >= 10 && n < 20);
            bus.updIndex      = 10'h005;
            bus.updTaken      = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        bus.predValid = 1'b0;
        bus.updValid  = 1'b0;
        checks++;
        if (n != DEPTH) begin
            errors++;
            $display("FAIL init_length: ready after %0d cycles, want %0d", n, DEPTH);
        end
        drive(1'b1, 10'h005, 10'h000, 1'b0, '0, 1'b0);
        wait_drain("init_ignore");
    endtask

    task automatic test_all_not_taken();
        idx_t gh;
        for (int i = 0; i < DEPTH; i++) begin
            gh = idx_t'($urandom_range(0, DEPTH - 1));
            drive(1'b1, idx_t'(i) ^ gh, gh, 1'b0, '0, 1'b0);
        end
        wait_drain("all_not_taken");
    endtask

    task automatic test_pred_index();
        drive(1'b1, 10'h00F, 10'h0F0, 1'b0, '0, 1'b0);
        wait_drain("pred_index");
    endtask

    task automatic test_taken_saturate();
        repeat (3) drive(1'b0, '0, '0, 1'b1, 10'h0FF, 1'b1);
        drive(1'b1, 10'h0FF, 10'h000, 1'b0, '0, 1'b0);
        drive(1'b1, 10'h0F0, 10'h00F, 1'b0, '0, 1'b0);
        // Walk back down to 01 for the forwarding scenario.
        repeat (2) drive(1'b0, '0, '0, 1'b1, 10'h0FF, 1'b0);
        drive(1'b1, 10'h0FF, 10'h000, 1'b0, '0, 1'b0);
        wait_drain("taken_saturate");
    endtask

    task automatic test_forward_pred();
        drive(1'b1, 10'h0FF, 10'h000, 1'b1, 10'h0FF, 1'b1);
        drive(1'b1, 10'h0FF, 10'h000, 1'b0, '0, 1'b0);
        wait_drain("forward_pred");
    endtask

    task automatic test_not_taken_floor();
        repeat (4) drive(1'b0, '0, '0, 1'b1, 10'h3FF, 1'b0);
        drive(1'b1, 10'h3FF, 10'h000, 1'b0, '0, 1'b0);
        drive(1'b1, 10'h3FF, 10'h000, 1'b1, 10'h3FF, 1'b1);
        drive(1'b1, 10'h3FF, 10'h000, 1'b1, 10'h3FF, 1'b1);
        drive(1'b1, 10'h3FF, 10'h000, 1'b0, '0, 1'b0);
        wait_drain("not_taken_floor");
    endtask

    task automatic test_back_to_back();
        idx_t set [4];
        idx_t gh;
        set[0] = 10'h0FF; set[1] = 10'h100; set[2] = 10'h101; set[3] = 10'h3FF;
        for (int i = 0; i < 300; i++) begin
            gh = idx_t'($urandom_range(0, DEPTH - 1));
            drive(1'($urandom_range(0, 3) != 0), set[$urandom_range(0, 3)] ^ gh, gh,
                  1'($urandom_range(0, 3) != 0), set[$urandom_range(0, 3)], 1'($urandom_range(0, 1)));
        end
        wait_drain("back_to_back");
    endtask

    task automatic test_reset_mid_init();
        int n;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (500) begin @(posedge clk); #1; end
        reset = 1'b1;
        #1;
        checks++;
        if (bus.ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_init_ready: got %b, want 0", bus.ready);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        count_init(n);
        checks++;
        if (n != DEPTH) begin
            errors++;
            $display("FAIL mid_init_length: ready after %0d cycles, want %0d", n, DEPTH);
        end
    endtask

    task automatic test_reset_mid_run();
        int   n;
        idx_t probe [4];
        probe[0] = 10'h0FF; probe[1] = 10'h3FF; probe[2] = 10'h123; probe[3] = 10'h000;
        model_reset();
        // Make every output non-zero, leave an update in flight, then reset.
        repeat (2) drive(1'b0, '0, '0, 1'b1, 10'h155, 1'b1);
        wait_drain("mid_run_setup");
        bus.predValid = 1'b1; bus.predPC = 10'h155; bus.globalHistory = 10'h000;
        bus.updValid  = 1'b1; bus.updIndex = 10'h123; bus.updTaken = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        bus.predValid = 1'b0;
        bus.updValid  = 1'b0;
        #1;
        checks++;
        if ({bus.ready, bus.predOutValid, bus.predTaken, bus.predIndex, bus.wasTaken, bus.resolved} !== '0) begin
            errors++;
            $display("FAIL mid_run_outputs: got rdy=%b pv=%b pt=%b pi=%h wt=%b res=%b, want all 0",
                     bus.ready, bus.predOutValid, bus.predTaken, bus.predIndex, bus.wasTaken, bus.resolved);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        count_init(n);
        checks++;
        if (n != DEPTH) begin
            errors++;
            $display("FAIL mid_run_length: ready after %0d cycles, want %0d", n, DEPTH);
        end
        // One taken step from 01 must flip each probe to predict taken.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, probe[i], 10'h000, 1'b1, probe[i], 1'b1);
            drive(1'b1, probe[i], 10'h000, 1'b0, '0, 1'b0);
        end
        wait_drain("mid_run_reinit");
    endtask

    initial begin
        reset             = 1'b1;
        bus.predValid     = 1'b0;
        bus.predPC        = '0;
        bus.globalHistory = '0;
        bus.updValid      = 1'b0;
        bus.updIndex      = '0;
        bus.updTaken      = 1'b0;
        fork
            monitor();
        join_none
        test_reset();
        test_all_not_taken();
        test_pred_index();
        test_taken_saturate();
        test_forward_pred();
        test_not_taken_floor();
        test_back_to_back();
        test_reset_mid_init();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gshare_pht.md
GSHARE_PHT -- requirements
Module: gshare_pht

Interface
REQ-001 SHALL have parameter G_WIDTH, default 9, with index width G_WIDTH+1 and table depth 2^(G_WIDTH+1).
REQ-002 SHALL have parameter INIT_CTR, default 2'b01 (weakly not-taken), which is the counter value loaded by initialisation.
REQ-003 SHALL have one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  sole clock, all state on posedge.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 predValid  input  1  prediction request this cycle.
REQ-007 predPC  input  G_WIDTH+1  low PC bits of the requesting branch.
REQ-008 globalHistory  input  G_WIDTH+1  current global history register value.
REQ-009 updValid  input  1  resolved-branch update this cycle.
REQ-010 updIndex  input  G_WIDTH+1  index returned with the original prediction.
REQ-011 updTaken  input  1  resolved outcome (1 = taken).
REQ-012 ready  output  1  table initialised, accepting requests.
REQ-013 predOutValid  output  1  predTaken/predIndex valid.
REQ-014 predTaken  output  1  predicted direction.
REQ-015 predIndex  output  G_WIDTH+1  index used, carried to resolution.
REQ-016 wasTaken  output  1  registered resolved outcome, driving the history register.
REQ-017 resolved  output  1  pulse qualifying wasTaken.

Function
REQ-018 Table SHALL hold 2^(G_WIDTH+1) 2-bit saturating counters; predicted taken = counter bit 1.
REQ-019 FSM states SHALL be INIT and RUN; reset enters INIT with initPtr = 0.
REQ-020 In INIT, each cycle SHALL write INIT_CTR to entry initPtr and increment initPtr; after writing entry depth-1, next state is RUN.
REQ-021 Init SHALL take exactly 2^(G_WIDTH+1) cycles (1024 at default); ready rises on the first RUN cycle.
REQ-022 In INIT, predValid and updValid SHALL be ignored, with no output pulses and no table change.
REQ-023 Prediction index SHALL be predPC XOR globalHistory.
REQ-024 Prediction latency SHALL be 1 cycle: predValid at edge t yields predOutValid=1, predTaken and predIndex at t+1; predOutValid is 0 otherwise.
REQ-025 Update SHALL be a 2-stage read-modify-write: stage 1 reads the counter at updIndex, stage 2 writes the saturated result one cycle later.
REQ-026 Counter arithmetic: taken increments, saturating at 3; not-taken decrements, saturating at 0; width stays 2 bits.
REQ-027 Back-to-back updates to the same index SHALL forward the stage-2 result into stage 1, so no update is lost.
REQ-028 A prediction reading the index being written by stage 2 in the same cycle SHALL return the newly written value.
REQ-029 One prediction and one update per cycle SHALL be supported concurrently.
REQ-030 wasTaken <= updTaken and resolved <= 1 one cycle after an accepted updValid; otherwise resolved = 0 and wasTaken holds its value.
REQ-031 Index arithmetic SHALL wrap modulo depth; no out-of-range access exists.

Reset
REQ-032 Async reset SHALL force ready=0, predOutValid=0, predTaken=0, predIndex=0, wasTaken=0, resolved=0, pipeline valids=0, state=INIT, initPtr=0.
REQ-033 Reset asserted mid-INIT or mid-RUN SHALL abort all in-flight updates and restart the full initialisation.
REQ-034 Counter storage SHALL NOT be reset directly; it is cleared only by the INIT sweep.

Structure
REQ-035 A shared package SHALL hold the G_WIDTH default, the counter typedef (2-bit), the state enum {INIT, RUN}, and the INIT_CTR constant.
REQ-036 A sub-module sat_counter2 (combinational 2-bit saturating next-value) SHALL be instantiated by stage 2.
REQ-037 Storage SHALL be a single-write-port array inferable as RAM, with the INIT write muxed onto the update write port.

Verification
REQ-038 Reset, then idle: ready=0 for 1024 cycles and 1 at cycle 1025; every index then predicts not-taken.
REQ-039 predPC=0x00F, globalHistory=0x0F0 -> one cycle later predIndex=0x0FF, predTaken=0, predOutValid=1.
REQ-040 Three taken updates to 0x0FF on consecutive cycles -> counter ends at 3 (01->10->11->11 saturate); a following prediction at 0x0FF returns 1.
REQ-041 Prediction at 0x0FF in the same cycle stage 2 writes 01->10 -> predTaken=1.
REQ-042 Four not-taken updates to 0x3FF -> counter reaches 0 and stays 0; resolved pulses 4 times with wasTaken=0.
REQ-043 Reset asserted at INIT cycle 500 and at RUN with an update in flight -> outputs are 0 immediately, a full 1024-cycle INIT follows, and all counters read as 01.
